// File: rtl/div_seq_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
// One quotient bit per cycle, with sign fix-up applied on entry to END.
module div_seq_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned SFT_W = 2 * DATA_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  cnt;
  logic [RES_W-1:0]  work;
  logic [DATA_W-1:0] divisor;
  logic              sign_q;
  logic              sign_r;

  logic [DATA_W-1:0] op1_abs, op2_abs;
  logic [SFT_W-1:0]  work_shift;
  logic [DATA_W:0]   trial;
  logic [RES_W-1:0]  work_step;
  logic [DATA_W-1:0] quo_fix, rem_fix;
  logic              last_iter;

  // Operand magnitudes; the most negative value maps onto itself as an unsigned number.
  always_comb begin
    op1_abs = opdata1_i;
    op2_abs = opdata2_i;
    if (signed_div_i && opdata1_i[DATA_W-1]) op1_abs = DATA_W'(0) - opdata1_i;
    if (signed_div_i && opdata2_i[DATA_W-1]) op2_abs = DATA_W'(0) - opdata2_i;
  end

  // One restoring step. The partial remainder never reaches the top bit of the
  // 65-bit working value, so only 64 bits are stored and the top bit lives in the shift.
  always_comb begin
    work_shift = {work, 1'b0};
    trial      = work_shift[SFT_W-1:DATA_W] - {1'b0, divisor};
    work_step  = work_shift[RES_W-1:0];
    if (!trial[DATA_W]) begin
      work_step = {trial[DATA_W-1:0], work_shift[DATA_W-1:1], 1'b1};
    end
    quo_fix = sign_q ? DATA_W'(0) - work_step[DATA_W-1:0] : work_step[DATA_W-1:0];
    rem_fix = sign_r ? DATA_W'(0) - work_step[RES_W-1:DATA_W] : work_step[RES_W-1:DATA_W];
  end

  assign last_iter = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          state_next = (opdata2_i == '0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: state_next = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)        state_next = S_IDLE;
        else if (last_iter) state_next = S_END;
      end
      S_END:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= (state_next == S_END);
      case (state)
        S_IDLE: begin
          if (state_next == S_ON) begin
            divisor <= op2_abs;
            sign_q  <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            sign_r  <= signed_div_i & opdata1_i[DATA_W-1];
            work    <= {DATA_W'(0), op1_abs};
            cnt     <= '0;
          end
        end
        S_ON: begin
          if (!annul_i) begin
            work <= work_step;
            cnt  <= cnt + CNT_W'(1);
            if (last_iter) result_o <= {rem_fix, quo_fix};
          end
        end
        S_DIVZERO: begin
          if (!annul_i) result_o <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed bench for div_seq_unit: latency, signed/unsigned results, divide-by-zero,
// annulment and asynchronous reset mid-divide.
module tb_div_seq_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  div_seq_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start at the current negedge; latency k means ready_o is seen in the cycle closing at edge T+k.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    lat          = 0;
    start_i      = 1'b1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_i   = 1'b0;
        opdata1_i = 32'hFFFF_FFFF;
        opdata2_i = 32'hFFFF_FFFF;
      end
      if (ready_o) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, result_o, exp_res);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(ready_o), 64'd0);
  endtask

  initial begin
    int seen;
    rst          = 1'b0;
    start_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    do_div("udiv_100_7", 32'd100, 32'd7, 1'b0, 33, 64'h00000002_0000000E);
    do_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 64'hFFFFFFFF_FFFFFFFD);
    do_div("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33, 64'h00000001_FFFFFFFD);

    do_div("divzero", 32'd5, 32'd0, 1'b0, 2, 64'd0);
    do_div("b2b_9_3", 32'd9, 32'd3, 1'b0, 33, 64'h00000000_00000003);

    // Annul an in-flight divide at edge T+10.
    seen         = 0;
    start_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    @(posedge clk);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1)  start_i = 1'b0;
      if (k == 10) annul_i = 1'b1;
      if (k == 11) annul_i = 1'b0;
      if (ready_o) seen = 1;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    chk("annul_hold", result_o, 64'h00000000_00000003);
    do_div("after_annul_10_3", 32'd10, 32'd3, 1'b0, 33, 64'h00000001_00000003);

    do_div("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 64'h00000000_80000000);
    do_div("udiv_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 64'h00000000_FFFFFFFF);
    do_div("udiv_3_max", 32'd3, 32'hFFFF_FFFF, 1'b0, 33, 64'h00000003_00000000);

    // Asynchronous reset between edges in the middle of a divide.
    start_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
    end
    #1 rst = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready_o), 64'd0);
    chk("midrst_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_div("after_rst_20_6", 32'd20, 32'd6, 1'b0, 33, 64'h00000002_00000003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq_unit.md
Name: div_seq_unit

Overview:
Multi-cycle radix-2 restoring divider. It is the responder side of the EX-stage divide handshake: the ALU raises start_i for DIV/DIVU and stalls until ready_o. It returns {remainder, quotient} for writing into HI/LO, and supports signed (DIV) and unsigned (DIVU) operation, divide-by-zero, and annulment on flush or exception.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W.
CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous and active-low.
start_i  input  1  divide request; sampled only in IDLE.
signed_div_i  input  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
opdata1_i  input  DATA_W  dividend; sampled with start_i.
opdata2_i  input  DATA_W  divisor; sampled with start_i.
annul_i  input  1  abort the in-flight divide (pipeline flush or exception).
result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; maps to {HI, LO}.
ready_o  output  1  one-cycle completion pulse; result_o is valid in this cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, ready_o=0, result_o=0, all internal registers 0. Reset mid-divide abandons the operation immediately.
- States: IDLE, DIVZERO, ON, END. All outputs are registered.
- IDLE:
  - start_i=1, annul_i=0, opdata2_i==0 -> DIVZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 -> ON. On this edge:
    - capture the operand magnitudes: if signed_div_i and operand MSB=1, take two's complement; otherwise pass unchanged;
    - latch sign_q = op1[31]^op2[31] and sign_r = op1[31];
    - load the working register W[64:0] = {33'b0, |op1|}; counter=0.
  - start_i=1 with annul_i=1 in the same cycle: annul wins; stay IDLE.
- ON, one iteration per cycle:
  - shift W left by 1;
  - trial = W[64:32] - {1'b0, |op2|};
  - if trial is non-negative (MSB=0), set W[64:32]=trial and W[0]=1; otherwise W[0]=0;
  - counter+1. After iteration DATA_W (counter==DATA_W-1 at the edge) -> END.
- Final fix-up on entry to END:
  - quotient = sign_q ? -W[31:0] : W[31:0];
  - remainder = sign_r ? -W[63:32] : W[63:32];
  - both forced unsigned when signed_div_i was 0.
- DIVZERO: next edge -> END with result 0 (quotient=0, remainder=0). No trap is raised.
- END: ready_o=1 for exactly this cycle and result_o is updated. Next edge -> IDLE unconditionally. result_o then holds its value until the next completion.
- annul_i=1 in DIVZERO or ON -> IDLE on the next edge. ready_o stays 0 and result_o is unchanged.
- annul_i in END is ignored; the pulse is still emitted.
- start_i is ignored outside IDLE. Operand changes after capture have no effect.
- Latency (start accepted at edge T):
  - normal divide: ready_o high in cycle T+DATA_W+1 (T+33);
  - divide-by-zero: ready_o high at T+2.
  - Back-to-back: the earliest next acceptance is the IDLE cycle after END.
- Arithmetic corner cases:
  - signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (wraps, no overflow flag);
  - |0x80000000| is carried as unsigned 0x80000000.

Test Plan:
1. Unsigned 100/7 (signed_div_i=0): start at T -> ready_o high only at T+33; result_o=0x00000002_0000000E.
2. Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD.
3. Divide-by-zero, 5/0 -> ready_o at T+2; result_o=0. Then a new start of 9/3 in the following IDLE cycle -> 0x00000000_00000003 at its own T+33.
4. Annul: start 100/7, annul_i=1 at T+10 -> no ready_o pulse within 40 cycles; result_o keeps its prior value. Next start of 10/3 -> 0x00000001_00000003.
5. Boundaries:
   - signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000;
   - unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF;
   - unsigned 3/0xFFFFFFFF -> 0x00000003_00000000.
6. Reset mid-operation: drive rst=0 asynchronously at T+15 (between clock edges) -> ready_o=0 and result_o=0 immediately. After release, 20/6 -> 0x00000002_00000003 at its T+33.
